// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter signal bundle.
//
// Purpose: groups the producer push channels and the CDB broadcast outputs
// of cdb_arbiter so they travel as one port.
//
// Handshake: for each source i, a push happens at the rising edge where
// src_valid[i] and src_ready[i] are both high (and the arbiter is running and
// not flushing). src_ready[i] never depends on src_valid[i]. A producer that
// raises src_valid[i] while src_ready[i] is low loses the entry and sets the
// sticky overflow_err flag.
//
// Signals:
//   src_valid    [NUM_SRC]     push request per source
//   src_tag      [4*NUM_SRC]   ROB tag, source i in bits [4i+3:4i]
//   src_val      [32*NUM_SRC]  result value
//   src_addr     [32*NUM_SRC]  result / branch target address
//   src_ready    [NUM_SRC]     FIFO i can accept an entry this cycle
//   cdb_active                 broadcast valid
//   cdb_tag/val/addr           broadcast payload
//   overflow_err               sticky: a push arrived while not ready
//
// Modports: master = producers / consumers side, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [4*NUM_SRC-1:0]  src_tag;
  logic [32*NUM_SRC-1:0] src_val;
  logic [32*NUM_SRC-1:0] src_addr;
  logic [NUM_SRC-1:0]    src_ready;
  logic                  cdb_active;
  logic [3:0]            cdb_tag;
  logic [31:0]           cdb_val;
  logic [31:0]           cdb_addr;
  logic                  overflow_err;

  modport master (
    output src_valid, src_tag, src_val, src_addr,
    input  src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, overflow_err
  );

  modport slave (
    input  src_valid, src_tag, src_val, src_addr,
    output src_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
//
// Purpose: each result producer pushes {tag, val, addr} into its own small
// FIFO; every cycle one non-empty FIFO head is chosen round-robin and driven
// onto the registered CDB outputs for one cycle.
//
// Ports:
//   clk_in    clock, rising edge
//   rst_in    asynchronous active-low reset
//   rdy_in    global run enable; low freezes all state and outputs
//   flush_in  synchronous mispredict flush (empties all FIFOs)
//   bus       cdb_arbiter_if.slave: producer push channels, src_ready,
//             CDB broadcast outputs and sticky overflow_err
module cdb_arbiter #(
  parameter int         NUM_SRC  = 3,
  parameter int         DEPTH    = 2,
  parameter logic [3:0] NONE_TAG = 4'b0000
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          flush_in,
  cdb_arbiter_if.slave bus
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
    logic [31:0] addr;
  } entry_t;

  entry_t          mem_q   [NUM_SRC][DEPTH];
  logic [AW-1:0]   head_q  [NUM_SRC];
  logic [AW-1:0]   tail_q  [NUM_SRC];
  logic [CW-1:0]   count_q [NUM_SRC];
  logic [PW-1:0]   rr_ptr_q;
  logic            cdb_active_q;
  logic [3:0]      cdb_tag_q;
  logic [31:0]     cdb_val_q;
  logic [31:0]     cdb_addr_q;
  logic            overflow_q;

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push_en;
  logic [NUM_SRC-1:0] pop_en;
  logic               ovf_evt;
  logic               grant_vld;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      scan_idx;
  logic [PW-1:0]      rr_next;
  entry_t             head_entry;

  // (base + off) mod NUM_SRC for off in 0..NUM_SRC-1.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return PW'(s);
  endfunction

  // Ready looks at the stored count only; a same-cycle pop does not free a slot.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = (count_q[i] < CW'(DEPTH));
    end
  end

  // Round-robin scan over FIFO heads. Scanning from the farthest offset back
  // to rr_ptr lets the nearest non-empty source win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      scan_idx = wrap_add(rr_ptr_q, k);
      if (count_q[scan_idx] != '0) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    rr_next    = wrap_add(grant_idx, 1);
    head_entry = mem_q[grant_idx][head_q[grant_idx]];
  end

  // Pushes carrying NONE_TAG are silently ignored, both as writes and as
  // overflow events. A flush discards same-cycle pushes without an error.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    ovf_evt = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rdy_in && !flush_in && bus.src_valid[i] && (bus.src_tag[4*i +: 4] != NONE_TAG)) begin
        if (ready[i]) push_en[i] = 1'b1;
        else          ovf_evt    = 1'b1;
      end
      if (rdy_in && !flush_in && grant_vld && (grant_idx == PW'(i))) begin
        pop_en[i] = 1'b1;
      end
    end
  end

  // Entry storage needs no reset: count/pointers define what is valid.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_en[i]) begin
        mem_q[i][tail_q[i]] <= '{tag:  bus.src_tag[4*i +: 4],
                                 val:  bus.src_val[32*i +: 32],
                                 addr: bus.src_addr[32*i +: 32]};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_ptr_q     <= '0;
      cdb_active_q <= 1'b0;
      cdb_tag_q    <= NONE_TAG;
      cdb_val_q    <= '0;
      cdb_addr_q   <= '0;
      overflow_q   <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          head_q[i]  <= '0;
          tail_q[i]  <= '0;
          count_q[i] <= '0;
        end
        rr_ptr_q     <= '0;
        cdb_active_q <= 1'b0;
        cdb_tag_q    <= NONE_TAG;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          head_q[i]  <= head_q[i] + AW'(pop_en[i]);
          tail_q[i]  <= tail_q[i] + AW'(push_en[i]);
          count_q[i] <= count_q[i] + CW'(push_en[i]) - CW'(pop_en[i]);
        end
        if (grant_vld) begin
          cdb_active_q <= 1'b1;
          cdb_tag_q    <= head_entry.tag;
          cdb_val_q    <= head_entry.val;
          cdb_addr_q   <= head_entry.addr;
          rr_ptr_q     <= rr_next;
        end else begin
          // val/addr keep the last broadcast payload.
          cdb_active_q <= 1'b0;
          cdb_tag_q    <= NONE_TAG;
        end
        if (ovf_evt) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.src_ready    = ready;
  assign bus.cdb_active   = cdb_active_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_val      = cdb_val_q;
  assign bus.cdb_addr     = cdb_addr_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed pushes with hand-ordered expected
// broadcasts in exp_q; a negedge monitor pops and compares every broadcast.
module tb_cdb_arbiter;

  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic rdy_in   = 1'b1;
  logic flush_in = 1'b0;
  logic upd_q    = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [67:0] exp_q[$];

  cdb_arbiter_if #(.NUM_SRC(3)) bus ();

  cdb_arbiter #(.NUM_SRC(3), .DEPTH(2), .NONE_TAG(4'b0000)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // Outputs only carry a fresh broadcast after an edge where the DUT ran.
  always @(posedge clk_in) upd_q <= rdy_in;

  // ---------------- driver tasks ----------------
  task automatic clear_src();
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_val   = '0;
    bus.src_addr  = '0;
  endtask

  task automatic set_src(input int s, input logic [3:0] t, input logic [31:0] v,
                         input logic [31:0] a);
    bus.src_valid[s]         = 1'b1;
    bus.src_tag[4*s +: 4]    = t;
    bus.src_val[32*s +: 32]  = v;
    bus.src_addr[32*s +: 32] = a;
  endtask

  task automatic exp_push(input logic [3:0] t, input logic [31:0] v, input logic [31:0] a);
    exp_q.push_back({t, v, a});
  endtask

  // Commit the driven inputs at the next edge, then drop one-shot inputs.
  task automatic step();
    @(posedge clk_in);
    #1;
    clear_src();
    flush_in = 1'b0;
  endtask

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    logic [67:0] e;
    if (rst_in && upd_q && bus.cdb_active) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bcast actual=%0h expected=none",
                 {bus.cdb_tag, bus.cdb_val, bus.cdb_addr});
      end else begin
        e = exp_q.pop_front();
        if ({bus.cdb_tag, bus.cdb_val, bus.cdb_addr} !== e) begin
          errors++;
          $display("FAIL bcast actual=%0h expected=%0h",
                   {bus.cdb_tag, bus.cdb_val, bus.cdb_addr}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_src();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_active", {67'd0, bus.cdb_active}, 68'd0);
    chk("rst_tag", {64'd0, bus.cdb_tag}, 68'd0);
    chk("rst_val", {36'd0, bus.cdb_val}, 68'd0);
    chk("rst_addr", {36'd0, bus.cdb_addr}, 68'd0);
    chk("rst_ovf", {67'd0, bus.overflow_err}, 68'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_ready", {65'd0, bus.src_ready}, 68'h7);
    chk("rst_idle", {67'd0, bus.cdb_active}, 68'd0);

    // Round-robin: rr_ptr=0, so 1,2,3 then 4,5,6.
    exp_push(4'h1, 32'h0000_0101, 32'h0000_1000);
    exp_push(4'h2, 32'h0000_0102, 32'h0000_1004);
    exp_push(4'h3, 32'h0000_0103, 32'h0000_1008);
    set_src(0, 4'h1, 32'h0000_0101, 32'h0000_1000);
    set_src(1, 4'h2, 32'h0000_0102, 32'h0000_1004);
    set_src(2, 4'h3, 32'h0000_0103, 32'h0000_1008);
    step();
    repeat (5) step();
    exp_push(4'h4, 32'h0000_0204, 32'h0000_2000);
    exp_push(4'h5, 32'h0000_0205, 32'h0000_2004);
    exp_push(4'h6, 32'h0000_0206, 32'h0000_2008);
    set_src(0, 4'h4, 32'h0000_0204, 32'h0000_2000);
    set_src(1, 4'h5, 32'h0000_0205, 32'h0000_2004);
    set_src(2, 4'h6, 32'h0000_0206, 32'h0000_2008);
    step();
    repeat (5) step();
    chk("rr_drain", 68'(exp_q.size()), 68'd0);

    // Single push latency: visible only after the second edge, for one cycle.
    exp_push(4'h3, 32'h0000_00AA, 32'h0000_0100);
    set_src(0, 4'h3, 32'h0000_00AA, 32'h0000_0100);
    step();
    @(negedge clk_in);
    chk("lat_t0", {67'd0, bus.cdb_active}, 68'd0);
    step();
    @(negedge clk_in);
    chk("lat_t1", {67'd0, bus.cdb_active}, 68'd1);
    step();
    @(negedge clk_in);
    chk("lat_t2_active", {67'd0, bus.cdb_active}, 68'd0);
    chk("lat_t2_tag", {64'd0, bus.cdb_tag}, 68'd0);
    chk("lat_t2_val_hold", {36'd0, bus.cdb_val}, 68'hAA);

    // Flush: rr_ptr=1; second push edge pops src1 (tag 2), then flush.
    set_src(0, 4'h1, 32'h0000_0311, 32'h0000_3000);
    set_src(1, 4'h2, 32'h0000_0312, 32'h0000_3004);
    set_src(2, 4'h3, 32'h0000_0313, 32'h0000_3008);
    step();
    exp_push(4'h2, 32'h0000_0312, 32'h0000_3004);
    set_src(0, 4'h4, 32'h0000_0314, 32'h0000_300C);
    set_src(1, 4'h5, 32'h0000_0315, 32'h0000_3010);
    set_src(2, 4'h6, 32'h0000_0316, 32'h0000_3014);
    step();
    flush_in = 1'b1;
    set_src(2, 4'h5, 32'h0000_0355, 32'h0000_3055);
    set_src(0, 4'h7, 32'h0000_0377, 32'h0000_3077);
    step();
    @(negedge clk_in);
    chk("flush_active", {67'd0, bus.cdb_active}, 68'd0);
    chk("flush_tag", {64'd0, bus.cdb_tag}, 68'd0);
    chk("flush_ready", {65'd0, bus.src_ready}, 68'h7);
    chk("flush_ovf", {67'd0, bus.overflow_err}, 68'd0);
    repeat (4) step();
    chk("flush_drain", 68'(exp_q.size()), 68'd0);

    // Backpressure: rr_ptr=0. Expected order A, C, B, 7, D, 8; tag 9 dropped.
    exp_push(4'hA, 32'h0000_040A, 32'h0000_4000);
    exp_push(4'hC, 32'h0000_040C, 32'h0000_4008);
    exp_push(4'hB, 32'h0000_040B, 32'h0000_4004);
    exp_push(4'h7, 32'h0000_0407, 32'h0000_4070);
    exp_push(4'hD, 32'h0000_040D, 32'h0000_400C);
    exp_push(4'h8, 32'h0000_0408, 32'h0000_4080);
    set_src(0, 4'hA, 32'h0000_040A, 32'h0000_4000);
    step();
    set_src(0, 4'hB, 32'h0000_040B, 32'h0000_4004);
    set_src(2, 4'hC, 32'h0000_040C, 32'h0000_4008);
    step();
    set_src(1, 4'h7, 32'h0000_0407, 32'h0000_4070);
    set_src(0, 4'hD, 32'h0000_040D, 32'h0000_400C);
    step();
    set_src(1, 4'h8, 32'h0000_0408, 32'h0000_4080);
    step();
    @(negedge clk_in);
    chk("bp_ready", {65'd0, bus.src_ready}, 68'h5);
    chk("bp_ovf_before", {67'd0, bus.overflow_err}, 68'd0);
    set_src(1, 4'h9, 32'h0000_0409, 32'h0000_4090);
    step();
    @(negedge clk_in);
    chk("bp_ovf_after", {67'd0, bus.overflow_err}, 68'd1);
    repeat (4) step();
    chk("bp_drain", 68'(exp_q.size()), 68'd0);

    // Pause: rr_ptr=2, so 3 pops first; then freeze for 4 edges; then 1, 2.
    exp_push(4'h3, 32'h0000_05C3, 32'h0000_5008);
    exp_push(4'h1, 32'h0000_05C1, 32'h0000_5000);
    exp_push(4'h2, 32'h0000_05C2, 32'h0000_5004);
    set_src(0, 4'h1, 32'h0000_05C1, 32'h0000_5000);
    set_src(1, 4'h2, 32'h0000_05C2, 32'h0000_5004);
    set_src(2, 4'h3, 32'h0000_05C3, 32'h0000_5008);
    step();
    step();
    rdy_in = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_src(0, 4'h9, 32'h0000_0599, 32'h0000_5099);
      step();
      @(negedge clk_in);
      chk($sformatf("pause_active_%0d", p), {67'd0, bus.cdb_active}, 68'd1);
      chk($sformatf("pause_tag_%0d", p), {64'd0, bus.cdb_tag}, 68'h3);
      chk($sformatf("pause_val_%0d", p), {36'd0, bus.cdb_val}, 68'h5C3);
    end
    rdy_in = 1'b1;
    repeat (4) step();
    chk("pause_drain", 68'(exp_q.size()), 68'd0);

    // Async reset mid-run: E broadcasts, F is still queued and must vanish.
    exp_push(4'hE, 32'h0000_060E, 32'h0000_6000);
    set_src(0, 4'hE, 32'h0000_060E, 32'h0000_6000);
    set_src(1, 4'hF, 32'h0000_060F, 32'h0000_6004);
    step();
    step();
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    #1;
    chk("arst_active", {67'd0, bus.cdb_active}, 68'd0);
    chk("arst_tag", {64'd0, bus.cdb_tag}, 68'd0);
    chk("arst_val", {36'd0, bus.cdb_val}, 68'd0);
    chk("arst_addr", {36'd0, bus.cdb_addr}, 68'd0);
    chk("arst_ovf", {67'd0, bus.overflow_err}, 68'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("arst_ready", {65'd0, bus.src_ready}, 68'h7);
    chk("arst_idle", {67'd0, bus.cdb_active}, 68'd0);
    repeat (4) step();
    chk("final_drain", 68'(exp_q.size()), 68'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
